// File: rtl/ppa_add_sched.sv
// Round-robin scheduler that shares one W-bit combinational adder among NREQ requesters.
// Each WORDS*W-bit addition is fed to the adder one slice per cycle, LSB first, with the carry chained.
module ppa_add_sched #(
  parameter int NREQ  = 2,
  parameter int WORDS = 4,
  parameter int W     = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WORDS*W-1:0] req_a,
  input  logic [NREQ*WORDS*W-1:0] req_b,
  input  logic [NREQ-1:0]         req_cin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WORDS*W-1:0]      rsp_sum,
  output logic                    rsp_cout,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy,
  output logic [W-1:0]            add_a,
  output logic [W-1:0]            add_b,
  output logic                    add_cin,
  input  logic [W-1:0]            add_sum,
  input  logic                    add_cout
);

  localparam int OPW = WORDS * W;
  localparam int CW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt, grant_idx, id;
  logic           grant_any, accept, last;
  logic [OPW-1:0] a_sh, b_sh, res, res_cur;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic [OPW-1:0] op_a [NREQ];
  logic [OPW-1:0] op_b [NREQ];
  int             arb_j;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g] = req_a[g*OPW +: OPW];
    assign op_b[g] = req_b[g*OPW +: OPW];
  end

  // The slice being produced this cycle replaces its place in the partial result.
  for (genvar g = 0; g < WORDS; g++) begin : g_res
    assign res_cur[g*W +: W] = (cnt == CW'(g)) ? add_sum : res[g*W +: W];
  end

  // Search starts at rr_ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_j = int'(rr_ptr) + k;
      if (arb_j >= NREQ) arb_j = arb_j - NREQ;
      if (!grant_any && req_valid[IDW'(arb_j)]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(arb_j);
      end
    end
  end

  assign rr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  assign accept = |(req_valid & req_ready);
  assign last   = (cnt == CW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Adder inputs and req_ready are forced to zero outside their active state and during reset.
  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    busy      = (state != IDLE);
    if (state == IDLE && !rst && grant_any) req_ready[grant_idx] = 1'b1;
    if (state == RUN) begin
      add_a   = a_sh[W-1:0];
      add_b   = b_sh[W-1:0];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      id        <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_sh   <= op_a[grant_idx];
          b_sh   <= op_b[grant_idx];
          carry  <= req_cin[grant_idx];
          id     <= grant_idx;
          cnt    <= '0;
          res    <= '0;
          rr_ptr <= rr_nxt;
        end
        RUN: begin
          a_sh  <= a_sh >> W;
          b_sh  <= b_sh >> W;
          carry <= add_cout;
          res   <= res_cur;
          cnt   <= cnt + 1'b1;
          if (last) begin
            rsp_sum   <= res_cur;
            rsp_cout  <= add_cout;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ppa_add_sched.sv
// Directed bench for ppa_add_sched (NREQ=2, WORDS=4, W=8) with a behavioural 8-bit adder
// closing the loop on the shared-adder ports.
module tb_ppa_add_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_cin;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_cout;
  logic [31:0] rsp_sum;
  logic [0:0]  rsp_id;
  logic        busy;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int total = 0;
  int bad   = 0;

  ppa_add_sched #(.NREQ(2), .WORDS(4), .W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] cin_seq;
    int         last_acc, nacc, exp_id, exp_rsp_id;

    // 1: reset with random inputs
    rst       = 1'b1;
    req_valid = 2'($urandom);
    req_cin   = 2'($urandom);
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    rsp_ready = 1'($urandom);
    repeat (2) begin
      step;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_add_cin", add_cin, 0);
    end
    rst       = 1'b0;
    req_valid = 2'b00;
    req_cin   = 2'b00;
    rsp_ready = 1'b0;

    // 2: single op on req0, carry ripples into slice 1
    req_a     = {32'h0, 32'h0000_00FF};
    req_b     = {32'h0, 32'h0000_0001};
    req_valid = 2'b01;
    #1;
    check("t2_req_ready", req_ready, 2'b01);
    step;
    req_valid = 2'b00;
    check("t2_busy", busy, 1);
    cin_seq = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      check("t2_add_cin", add_cin, cin_seq[k]);
      check("t2_no_rsp", rsp_valid, 0);
      step;
    end
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_sum", rsp_sum, 32'h0000_0100);
    check("t2_rsp_cout", rsp_cout, 0);
    check("t2_rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    step;
    check("t2_rsp_drop", rsp_valid, 0);
    check("t2_idle", busy, 0);

    // 3: overflow on req1, then 5: backpressure on its response
    req_a     = {32'hFFFF_FFFF, 32'h0};
    req_b     = 64'h0;
    req_cin   = 2'b10;
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    #1;
    check("t3_req_ready", req_ready, 2'b10);
    step;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      check("t3_add_a", add_a, 8'hFF);
      check("t3_add_b", add_b, 8'h00);
      check("t3_add_cin", add_cin, 1);
      check("t3_run_ready", req_ready, 0);
      step;
    end
    check("t3_rsp_valid", rsp_valid, 1);
    check("t3_rsp_sum", rsp_sum, 32'h0);
    check("t3_rsp_cout", rsp_cout, 1);
    check("t3_rsp_id", rsp_id, 1);
    repeat (3) begin
      step;
      check("t5_hold_valid", rsp_valid, 1);
      check("t5_hold_sum", rsp_sum, 32'h0);
      check("t5_hold_cout", rsp_cout, 1);
      check("t5_hold_id", rsp_id, 1);
      check("t5_busy", busy, 1);
      check("t5_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step;
    check("t5_release_valid", rsp_valid, 0);
    check("t5_release_busy", busy, 0);
    check("t5_release_ready", req_ready, 2'b01);

    // 4: contention, both requesters always valid
    req_a   = {32'h8000_0000, 32'h1234_5678};
    req_b   = {32'h8000_0000, 32'h1111_1111};
    req_cin = 2'b00;
    last_acc   = -1;
    nacc       = 0;
    exp_id     = 0;
    exp_rsp_id = 0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      if (req_ready != 2'b00) begin
        check("t4_onehot", 64'($onehot(req_ready)), 1);
        check("t4_grant", req_ready, (exp_id == 0) ? 2'b01 : 2'b10);
        if (last_acc >= 0) check("t4_interval", cyc - last_acc, 6);
        last_acc = cyc;
        exp_id   = 1 - exp_id;
        nacc++;
      end
      if (rsp_valid) begin
        check("t4_rsp_id", rsp_id, exp_rsp_id);
        check("t4_rsp_sum", rsp_sum, (exp_rsp_id == 0) ? 32'h2345_6789 : 32'h0);
        check("t4_rsp_cout", rsp_cout, (exp_rsp_id == 0) ? 1'b0 : 1'b1);
        exp_rsp_id = 1 - exp_rsp_id;
      end
      step;
    end
    check("t4_accepts", nacc, 5);

    // 6: reset during RUN aborts the req1 transaction
    rst = 1'b1;
    step;
    check("t6_rst_busy", busy, 0);
    rst       = 1'b0;
    req_valid = 2'b10;
    #1;
    check("t6_req1_ready", req_ready, 2'b10);
    step;
    step;
    step;
    check("t6_in_run", busy, 1);
    rst = 1'b1;
    step;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_valid", rsp_valid, 0);
    check("t6_abort_add_a", add_a, 0);
    rst       = 1'b0;
    req_valid = 2'b11;
    #1;
    check("t6_req0_wins", req_ready, 2'b01);
    step;
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      check("t6_no_stale_rsp", rsp_valid, 0);
      step;
    end
    check("t6_rsp_valid", rsp_valid, 1);
    check("t6_rsp_id", rsp_id, 0);
    check("t6_rsp_sum", rsp_sum, 32'h2345_6789);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppa_add_sched.md
Name: ppa_add_sched

Overview:
Round-robin scheduler that shares one combinational W-bit prefix adder instance among NREQ requesters. Each requester submits a WORDS*W-bit addition, and the block serialises it onto the shared adder one W-bit slice per cycle, LSB slice first. It chains the carry between slices and returns the full sum and carry-out on a single tagged response channel. It sits between client logic and the adder, and drives the adder's a/b/cin inputs directly.

Parameters:
NREQ, 2, number of requesters (2..8).
WORDS, 4, W-bit slices per operand (1..16).
W, 8, shared adder width; must equal the instantiated adder width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  NREQ  per-requester request valid.
req_ready  output  NREQ  per-requester accept; one-hot or zero.
req_a  input  NREQ*WORDS*W  operand A; requester i occupies bits [i*WORDS*W +: WORDS*W].
req_b  input  NREQ*WORDS*W  operand B; same packing as req_a.
req_cin  input  NREQ  per-requester carry-in.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response accept.
rsp_sum  output  WORDS*W  full sum.
rsp_cout  output  1  final carry-out.
rsp_id  output  clog2(NREQ) (min 1)  index of the requester being answered.
busy  output  1  high when state != IDLE.
add_a  output  W  to shared adder a.
add_b  output  W  to shared adder b.
add_cin  output  1  to shared adder cin.
add_sum  input  W  from shared adder sum; combinational, same cycle.
add_cout  input  1  from shared adder cout; combinational, same cycle.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
  - busy=0, req_ready=0.
  - add_a=0, add_b=0, add_cin=0.
  - All internal registers are cleared.
- Reset takes priority over all events. Reset mid-operation aborts the transaction: no response is produced and the operation is not retried.
- The state machine has three states: IDLE, RUN and RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[i] = grant[i] (combinational from req_valid). req_ready is 0 in all other states.
  - Accept occurs when req_valid[i] & req_ready[i]. On accept:
    - latch the operands into A/B shift registers;
    - carry <= req_cin[i], id <= i, cnt <= 0;
    - rr_ptr <= (i+1) mod NREQ;
    - go to RUN.
  - A requester may deassert req_valid before accept with no side effect.
- RUN:
  - add_a = A_sh[W-1:0], add_b = B_sh[W-1:0], add_cin = carry. These are 0 outside RUN.
  - Each cycle: result slice[cnt] <= add_sum; carry <= add_cout; A_sh and B_sh shift right by W; cnt++.
  - After slice WORDS-1 is captured: rsp_sum <= assembled result, rsp_cout <= add_cout, rsp_id <= id, rsp_valid <= 1; go to RESP.
  - RUN lasts exactly WORDS cycles.
- RESP:
  - rsp_valid, rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid <= 0; go to IDLE.
  - rsp_ready high in the first RESP cycle completes the handshake in that cycle.
- Latency:
  - Accept at cycle T; RUN occupies T+1..T+WORDS; rsp_valid=1 from T+WORDS+1.
  - Minimum issue interval is WORDS+2 cycles.
- Arithmetic: result = (A + B + cin) mod 2^(WORDS*W); rsp_cout = bit WORDS*W of the full sum. The block relies on the adder being correct and performs no internal addition.
- Requests arriving during RUN or RESP are not accepted; they are arbitrated on the next IDLE cycle.
- Only one transaction is in flight at a time. No buffering beyond the single response register.

Test Plan:
1. Reset: assert rst for 2 cycles with random inputs -> every output is 0 and busy=0; first accept after release goes to req0 (rr_ptr=0).
2. Single op, WORDS=4: req0 a=0x000000FF, b=0x00000001, cin=0 -> add_cin sequence over RUN is 0,1,0,0; rsp_valid at T+5 with rsp_sum=0x00000100, rsp_cout=0, rsp_id=0.
3. Overflow: req1 a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_sum=0x00000000, rsp_cout=1, rsp_id=1; add_a slices 0xFF,0xFF,0xFF,0xFF.
4. Contention: req0 and req1 valid continuously with rsp_ready=1 -> grant order 0,1,0,1; accepts spaced exactly 6 cycles; req_ready never has two bits set.
5. Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_* stable, busy=1, req_ready=0 throughout; release -> IDLE next cycle, next accept the cycle after.
6. Reset mid-RUN: assert rst after 2 RUN cycles of a req1 op -> rsp_valid never rises for it; with both requests pending after reset, req0 wins.
